// File: rtl/job_dispatcher.sv
// Job dispatcher: queues operands in a small FIFO and drives the engine
// start/done handshake, one job at a time, with a done timeout.
module job_dispatcher #(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     eng_start,
    output logic [DATA_W-1:0]        eng_data,
    input  logic                     eng_done,
    output logic                     busy,
    output logic                     job_done,
    output logic                     timeout,
    output logic [CNT_W-1:0]         jobs_cnt,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_GAP
    } state_t;

    state_t state, next;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [TW-1:0]     timer;
    logic              push, pop, done_hit, to_hit;

    // No full-bypass: readiness depends only on the registered level.
    assign in_ready = rst && (fifo_level != LW'(DEPTH));
    assign push     = in_valid && in_ready;

    always_comb begin
        next     = state;
        pop      = 1'b0;
        done_hit = 1'b0;
        to_hit   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (fifo_level != '0) begin
                    pop  = 1'b1;
                    next = S_LAUNCH;
                end
            end
            S_LAUNCH: next = S_WAIT;
            S_WAIT: begin
                // Done has priority over a timer expiring in the same cycle.
                if (eng_done) begin
                    done_hit = 1'b1;
                    next     = S_GAP;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    to_hit = 1'b1;
                    next   = S_GAP;
                end
            end
            S_GAP:   next = S_IDLE;
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            timer      <= '0;
            fifo_level <= '0;
            eng_start  <= 1'b0;
            eng_data   <= '0;
            busy       <= 1'b0;
            job_done   <= 1'b0;
            timeout    <= 1'b0;
            jobs_cnt   <= '0;
        end else begin
            state     <= next;
            busy      <= (next != S_IDLE);
            eng_start <= pop;
            job_done  <= done_hit;
            timeout   <= to_hit;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                eng_data <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + 1'b1;
            end else if (pop && !push) begin
                fifo_level <= fifo_level - 1'b1;
            end
            if (state == S_LAUNCH) begin
                timer <= '0;
            end else if (state == S_WAIT) begin
                timer <= timer + 1'b1;
            end
            if (done_hit) begin
                jobs_cnt <= jobs_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_job_dispatcher.sv
// Bench for job_dispatcher: per-cycle vector table for reset and a single
// job, then hand sequences for fill, timeout, coincidence and mid-job reset.
module tb_job_dispatcher;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        eng_start;
    logic [15:0] eng_data;
    logic        eng_done;
    logic        busy;
    logic        job_done;
    logic        timeout;
    logic [7:0]  jobs_cnt;
    logic [2:0]  fifo_level;

    job_dispatcher #(
        .DATA_W (16),
        .DEPTH  (4),
        .TIMEOUT(8),
        .CNT_W  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .eng_start (eng_start),
        .eng_data  (eng_data),
        .eng_done  (eng_done),
        .busy      (busy),
        .job_done  (job_done),
        .timeout   (timeout),
        .jobs_cnt  (jobs_cnt),
        .fifo_level(fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        iv;
        logic [15:0] din;
        logic        dn;
        logic        rdy;
        logic        st;
        logic [15:0] dat;
        logic        jd;
        logic        to;
        logic        bsy;
        logic [7:0]  cnt;
        logic [2:0]  lvl;
    } vec_t;

    int          nvec = 0;
    int          nerr = 0;
    logic [15:0] exp_q[$];
    vec_t        tbl[12];

    function automatic vec_t mk(logic r, logic iv, logic [15:0] din,
                                logic dn, logic rdy, logic st,
                                logic [15:0] dat, logic jd, logic to,
                                logic bsy, logic [7:0] cnt,
                                logic [2:0] lvl);
        vec_t v;
        v.r = r;     v.iv = iv;   v.din = din; v.dn = dn;
        v.rdy = rdy; v.st = st;   v.dat = dat; v.jd = jd;
        v.to = to;   v.bsy = bsy; v.cnt = cnt; v.lvl = lvl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic cyc(input logic r, input logic v,
                       input logic [15:0] d, input logic dn);
        @(posedge clk);
        #1;
        rst      = r;
        in_valid = v;
        in_data  = d;
        eng_done = dn;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            cyc(1'b1, 1'b0, 16'h0, 1'b0);
            chk("no_timeout", timeout, 0);
            chk("no_done", job_done, 0);
        end
    endtask

    // Scoreboard: every launch must carry the oldest accepted operand.
    always @(negedge clk) begin
        if (rst && eng_start) begin
            if (exp_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL launch_order: got %0h want no launch",
                         eng_data);
            end else begin
                chk("launch_data", eng_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [15:0] jobs [5];
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        eng_done = 1'b0;
        jobs[0] = 16'h2222; jobs[1] = 16'h3333; jobs[2] = 16'h4444;
        jobs[3] = 16'h5555; jobs[4] = 16'h6666;

        tbl[0]  = mk(0, 0, 16'h0,  0, 0, 0, 16'h0,  0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 16'h0,  0, 1, 0, 16'h0,  0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 1, 16'hA5, 0, 1, 0, 16'h0,  0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 0, 16'h0,  0, 1, 0, 16'h0,  0, 0, 0, 0, 1);
        tbl[4]  = mk(1, 0, 16'h0,  0, 1, 1, 16'hA5, 0, 0, 1, 0, 0);
        tbl[5]  = mk(1, 0, 16'h0,  0, 1, 0, 16'hA5, 0, 0, 1, 0, 0);
        tbl[6]  = mk(1, 0, 16'h0,  0, 1, 0, 16'hA5, 0, 0, 1, 0, 0);
        tbl[7]  = mk(1, 0, 16'h0,  0, 1, 0, 16'hA5, 0, 0, 1, 0, 0);
        tbl[8]  = mk(1, 0, 16'h0,  1, 1, 0, 16'hA5, 0, 0, 1, 0, 0);
        tbl[9]  = mk(1, 0, 16'h0,  0, 1, 0, 16'hA5, 1, 0, 1, 1, 0);
        tbl[10] = mk(1, 0, 16'h0,  0, 1, 0, 16'hA5, 0, 0, 0, 1, 0);
        tbl[11] = mk(1, 0, 16'h0,  0, 1, 0, 16'hA5, 0, 0, 0, 1, 0);

        cyc(1'b0, 1'b0, 16'h0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].iv && tbl[i].rdy) exp_q.push_back(tbl[i].din);
            cyc(tbl[i].r, tbl[i].iv, tbl[i].din, tbl[i].dn);
            chk("t_in_ready", in_ready, tbl[i].rdy);
            chk("t_eng_start", eng_start, tbl[i].st);
            chk("t_eng_data", eng_data, tbl[i].dat);
            chk("t_job_done", job_done, tbl[i].jd);
            chk("t_timeout", timeout, tbl[i].to);
            chk("t_busy", busy, tbl[i].bsy);
            chk("t_jobs_cnt", jobs_cnt, tbl[i].cnt);
            chk("t_level", fifo_level, tbl[i].lvl);
        end

        // Job 1111 launches, then fill the FIFO while it is stalled.
        exp_q.push_back(16'h1111);
        cyc(1'b1, 1'b1, 16'h1111, 1'b0);
        cyc(1'b1, 1'b0, 16'h0, 1'b0);
        cyc(1'b1, 1'b0, 16'h0, 1'b0);
        chk("start_1111", eng_start, 1);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(jobs[i]);
            cyc(1'b1, 1'b1, jobs[i], 1'b0);
            chk("fill_ready", in_ready, (i < 4) ? 1 : 0);
            chk("fill_level", fifo_level, i);
        end
        cyc(1'b1, 1'b0, 16'h0, 1'b0);
        chk("full_level", fifo_level, 4);
        chk("full_ready", in_ready, 0);
        idle(2);
        cyc(1'b1, 1'b0, 16'h0, 1'b0);
        chk("to1_pulse", timeout, 1);
        chk("to1_nodone", job_done, 0);
        chk("to1_cnt", jobs_cnt, 1);
        cyc(1'b1, 1'b0, 16'h0, 1'b0);
        chk("to1_gap", eng_start, 0);

        // Job 2222: stray done during LAUNCH must be ignored.
        cyc(1'b1, 1'b0, 16'h0, 1'b1);
        chk("start_2222", eng_start, 1);
        chk("lvl_after2", fifo_level, 3);
        idle(8);
        cyc(1'b1, 1'b0, 16'h0, 1'b0);
        chk("to2_pulse", timeout, 1);
        chk("to2_cnt", jobs_cnt, 1);
        cyc(1'b1, 1'b0, 16'h0, 1'b0);

        // Job 3333: done arrives on the expiry cycle.
        cyc(1'b1, 1'b0, 16'h0, 1'b0);
        chk("start_3333", eng_start, 1);
        idle(7);
        cyc(1'b1, 1'b0, 16'h0, 1'b1);
        chk("co_held", eng_data, 16'h3333);
        cyc(1'b1, 1'b0, 16'h0, 1'b0);
        chk("co_done", job_done, 1);
        chk("co_noto", timeout, 0);
        chk("co_cnt", jobs_cnt, 2);
        cyc(1'b1, 1'b0, 16'h0, 1'b0);
        chk("co_late_to", timeout, 0);
        cyc(1'b1, 1'b0, 16'h0, 1'b0);
        chk("start_4444", eng_start, 1);
        chk("lvl_after4", fifo_level, 1);

        // Reset mid-WAIT with queued jobs.
        cyc(1'b1, 1'b1, 16'h7777, 1'b0);
        cyc(1'b1, 1'b1, 16'h8888, 1'b0);
        cyc(1'b1, 1'b0, 16'h0, 1'b0);
        chk("pre_rst_lvl", fifo_level, 3);
        chk("pre_rst_busy", busy, 1);
        exp_q.delete();
        cyc(1'b0, 1'b0, 16'h0, 1'b0);
        chk("rst_ready", in_ready, 0);
        cyc(1'b1, 1'b0, 16'h0, 1'b0);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", jobs_cnt, 0);
        chk("rst_data", eng_data, 0);
        chk("rst_start", eng_start, 0);
        chk("rst_ready1", in_ready, 1);
        for (int k = 0; k < 12; k++) begin
            cyc(1'b1, 1'b0, 16'h0, 1'b1);
            chk("idle_done", job_done, 0);
            chk("idle_to", timeout, 0);
            chk("idle_busy", busy, 0);
            chk("idle_cnt", jobs_cnt, 0);
        end
        chk("sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
